stack_controller: RTL and testbench
===================================

# stack_controller

Initiator-side stack engine: accepts push/pop requests from the core, owns the stack pointer, and drives the stack half of the data memory (address, write data, write strobe, stack select), capturing registered read data on pops. It sits between the core's control path and the data memory's stack port, and turns single-cycle push/pop pulses into properly sequenced memory write and read transactions. Overflow and underflow are detected here and never reach memory.

## Interface
- DEPTH, 100, number of stack words; legal SP range 0..DEPTH
- SP_W, 7, stack pointer width; must hold DEPTH
- READ_LAT, 1, memory read latency in Clock cycles (address held → DataOut valid); range 1..3
- Clock  in  1  single clock; the memory's read clock is tied to it
- Reset  in  1  synchronous, active-high
- Push  in  1  push request, sampled only when Ready=1
- Pop  in  1  pop request, sampled only when Ready=1
- Clear  in  1  empty the stack (SP←0), sampled only when Ready=1; memory untouched
- PushData  in  32  word to push
- Ready  out  1  controller idle, requests sampled this cycle
- PopData  out  32  last popped word, held until next pop
- PopValid  out  1  one-cycle pulse, PopData updated
- Full  out  1  SP==DEPTH
- Empty  out  1  SP==0
- Overflow  out  1  sticky: push attempted while Full
- Underflow  out  1  sticky: pop attempted while Empty
- StackPointer  out  SP_W  current SP (next free slot)
- MemAddr  out  32  memory address, zero-extended SP index
- MemDataIn  out  32  memory write data
- MemWrite  out  1  memory write strobe
- MemUseStk  out  1  selects the stack array, high for the whole transaction
- MemDataOut  in  32  memory read data

## Operation
- States: IDLE, WRITE, READ_WAIT. Ready=1 only in IDLE and not in Reset. Full/Empty are combinational from SP.
- Request priority in IDLE: Clear > Pop > Push. Lower-priority requests in the same cycle are dropped silently and set no flag.
- Clear: SP←0 and stay in IDLE. Overflow and Underflow are not cleared.
- Pop with Empty=1: Underflow←1, stay IDLE, no memory activity.
- Pop with Empty=0: MemAddr←SP−1, MemUseStk←1, MemWrite←0, wait counter←READ_LAT, go to READ_WAIT.
- READ_WAIT: decrement the counter. When it reaches 0, on that edge: PopData←MemDataOut, PopValid←1, SP←SP−1, MemUseStk←0, go to IDLE.
- Push with Full=1: Overflow←1, stay IDLE, no memory activity.
- Push with Full=0: MemAddr←SP, MemDataIn←PushData, MemWrite←1, MemUseStk←1, go to WRITE.
- WRITE: after one cycle, MemWrite←0, MemUseStk←0, SP←SP+1, go to IDLE.
- All memory-side outputs are registered. MemAddr and MemDataIn hold their last values in IDLE.
- Overflow and Underflow clear only on Reset.
- Reset (any state, including mid-transaction): state←IDLE, SP←0, all outputs 0, so Empty=1 and Ready=0 during Reset. Aborted pops produce no PopValid. An aborted write is cut off: MemWrite falls at the Reset edge.

## Timing
- Push accepted at edge k: MemWrite high for exactly cycle k→k+1. Memory writes at edge k+1. SP increments at edge k+1. Ready is high again after edge k+1. Push throughput is one per 2 cycles.
- Pop accepted at edge k: MemAddr is stable from edge k. PopValid is high for one cycle after edge k+1+READ_LAT, in the same cycle that Ready returns to 1. With READ_LAT=1, pop latency is 2 cycles.
- PopValid never coincides with MemWrite.
- StackPointer updates on the same edge as PopValid rises or MemWrite falls.

## Test plan
- Reset → after release: Ready=1, Empty=1, Full=0, SP=0, PopValid=0, Overflow=0, Underflow=0, MemWrite=0.
- Push 0xDEADBEEF, then 0x12345678 → single-cycle MemWrite pulses at MemAddr 0 and 1, SP=2. Then two pops → PopData 0x12345678 then 0xDEADBEEF, each PopValid exactly 2 cycles after acceptance (READ_LAT=1), final SP=0.
- DEPTH=4: push 1,2,3,4 → Full=1. Fifth push 5 → Overflow=1, no MemWrite, SP=4. Pop → PopData=4.
- Empty stack, Pop → Underflow=1, MemUseStk stays 0, Ready stays 1. A later push of 0x0A succeeds and Underflow stays 1.
- SP=1, Push and Pop in the same cycle → pop served (PopData = stored word, SP=0) and no write occurs. Clear with Push in the same cycle at SP=3 → SP=0, no write.
- Push 0x55, then Pop, then Reset asserted during READ_WAIT (READ_LAT=3) → PopValid never pulses, SP=0, Ready=1 one cycle after Reset deasserts.

Source files
------------

// File: rtl/stack_controller.sv
// stack_controller: push/pop engine that owns the stack pointer and drives
// the stack port of the data memory. Push is a one-cycle write transaction;
// pop holds the address for READ_LAT cycles and then captures the
// registered read data. Overflow/underflow are trapped here and never
// reach memory.
module stack_controller #(
  parameter int unsigned DEPTH    = 100,
  parameter int unsigned SP_W     = 7,
  parameter int unsigned READ_LAT = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Push,
  input  logic            Pop,
  input  logic            Clear,
  input  logic [31:0]     PushData,
  output logic            Ready,
  output logic [31:0]     PopData,
  output logic            PopValid,
  output logic            Full,
  output logic            Empty,
  output logic            Overflow,
  output logic            Underflow,
  output logic [SP_W-1:0] StackPointer,
  output logic [31:0]     MemAddr,
  output logic [31:0]     MemDataIn,
  output logic            MemWrite,
  output logic            MemUseStk,
  input  logic [31:0]     MemDataOut
);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StReadWait
  } state_t;

  localparam logic [SP_W-1:0] SpDepth = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SpOne   = SP_W'(1);
  localparam logic [1:0]      LatInit = 2'(READ_LAT);

  state_t          state;
  logic [1:0]      waitCount;
  logic [SP_W-1:0] spMinusOne;

  // Status decoded straight from the stack pointer and controller state
  assign Full       = (StackPointer == SpDepth);
  assign Empty      = (StackPointer == '0);
  assign Ready      = (state == StIdle) && !Reset;
  assign spMinusOne = StackPointer - SpOne;

  // Controller FSM: request arbitration, memory sequencing and SP update
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= StIdle;
      StackPointer <= '0;
      waitCount    <= '0;
      PopData      <= '0;
      PopValid     <= 1'b0;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
      MemAddr      <= '0;
      MemDataIn    <= '0;
      MemWrite     <= 1'b0;
      MemUseStk    <= 1'b0;
    end else begin
      PopValid <= 1'b0;
      unique case (state)
        StIdle: begin
          // Clear beats Pop beats Push; losers are dropped without a flag
          if (Clear) begin
            StackPointer <= '0;
          end else if (Pop) begin
            if (Empty) begin
              Underflow <= 1'b1;
            end else begin
              MemAddr   <= 32'(spMinusOne);
              MemWrite  <= 1'b0;
              MemUseStk <= 1'b1;
              waitCount <= LatInit;
              state     <= StReadWait;
            end
          end else if (Push) begin
            if (Full) begin
              Overflow <= 1'b1;
            end else begin
              MemAddr   <= 32'(StackPointer);
              MemDataIn <= PushData;
              MemWrite  <= 1'b1;
              MemUseStk <= 1'b1;
              state     <= StWrite;
            end
          end
        end
        StWrite: begin
          MemWrite     <= 1'b0;
          MemUseStk    <= 1'b0;
          StackPointer <= StackPointer + SpOne;
          state        <= StIdle;
        end
        StReadWait: begin
          // Counter hits zero once the data is valid; capture on the next edge
          if (waitCount == '0) begin
            PopData      <= MemDataOut;
            PopValid     <= 1'b1;
            StackPointer <= spMinusOne;
            MemUseStk    <= 1'b0;
            state        <= StIdle;
          end else begin
            waitCount <= waitCount - 2'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: table-driven, hand-sequenced and random checks of
// stack_controller against a queue-based stack model and behavioural
// memories with 1- and 3-cycle read latency.
module tb_stack_controller;

  localparam int unsigned A_DEPTH = 4;
  localparam int unsigned A_SPW   = 3;
  localparam int unsigned A_RL    = 1;
  localparam int unsigned B_RL    = 3;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // DUT A: small stack, single-cycle read latency
  logic             aReset, aPush, aPop, aClear;
  logic [31:0]      aPushData, aPopData, aMemAddr, aMemDataIn, aMemDataOut;
  logic             aReady, aPopValid, aFull, aEmpty, aOvf, aUnf, aMemWrite, aMemUseStk;
  logic [A_SPW-1:0] aSp;

  // DUT B: default depth, three-cycle read latency
  logic        bReset, bPush, bPop, bClear;
  logic [31:0] bPushData, bPopData, bMemAddr, bMemDataIn, bMemDataOut;
  logic        bReady, bPopValid, bFull, bEmpty, bOvf, bUnf, bMemWrite, bMemUseStk;
  logic [6:0]  bSp;

  stack_controller #(.DEPTH(A_DEPTH), .SP_W(A_SPW), .READ_LAT(A_RL)) dutA (
    .Clock(Clock), .Reset(aReset), .Push(aPush), .Pop(aPop), .Clear(aClear),
    .PushData(aPushData), .Ready(aReady), .PopData(aPopData), .PopValid(aPopValid),
    .Full(aFull), .Empty(aEmpty), .Overflow(aOvf), .Underflow(aUnf),
    .StackPointer(aSp), .MemAddr(aMemAddr), .MemDataIn(aMemDataIn),
    .MemWrite(aMemWrite), .MemUseStk(aMemUseStk), .MemDataOut(aMemDataOut)
  );

  stack_controller #(.READ_LAT(B_RL)) dutB (
    .Clock(Clock), .Reset(bReset), .Push(bPush), .Pop(bPop), .Clear(bClear),
    .PushData(bPushData), .Ready(bReady), .PopData(bPopData), .PopValid(bPopValid),
    .Full(bFull), .Empty(bEmpty), .Overflow(bOvf), .Underflow(bUnf),
    .StackPointer(bSp), .MemAddr(bMemAddr), .MemDataIn(bMemDataIn),
    .MemWrite(bMemWrite), .MemUseStk(bMemUseStk), .MemDataOut(bMemDataOut)
  );

  // Behavioural memories: write on strobe, read data delayed by READ_LAT edges
  logic [31:0] memA [0:127];
  logic [31:0] pipeA;
  logic [31:0] memB [0:127];
  logic [31:0] pipeB [0:2];

  always @(posedge Clock) begin
    if (aMemWrite && aMemUseStk) memA[aMemAddr[6:0]] <= aMemDataIn;
    pipeA <= memA[aMemAddr[6:0]];
  end
  assign aMemDataOut = pipeA;

  always @(posedge Clock) begin
    if (bMemWrite && bMemUseStk) memB[bMemAddr[6:0]] <= bMemDataIn;
    pipeB[0] <= memB[bMemAddr[6:0]];
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end
  assign bMemDataOut = pipeB[2];

  // Reference model: the stack as a queue plus sticky flags
  logic [31:0] mStack [$];
  bit          mOvf, mUnf;
  logic [31:0] mPopData;

  typedef struct {
    bit          c, p, u;
    logic [31:0] d;
    int          eSp;
    logic [31:0] ePd;
    bit          eOvf, eUnf;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(bit c, bit p, bit u, logic [31:0] d,
                              int sp, logic [31:0] pd, bit o, bit un);
    vec_t v;
    v.c = c; v.p = p; v.u = u; v.d = d;
    v.eSp = sp; v.ePd = pd; v.eOvf = o; v.eUnf = un;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic resetA();
    aReset = 1'b1; aPush = 1'b0; aPop = 1'b0; aClear = 1'b0; aPushData = '0;
    repeat (2) @(negedge Clock);
    chk("rst_ready", aReady, 0);
    chk("rst_empty", aEmpty, 1);
    chk("rst_full", aFull, 0);
    chk("rst_sp", aSp, 0);
    chk("rst_popvalid", aPopValid, 0);
    chk("rst_memwrite", aMemWrite, 0);
    chk("rst_usestk", aMemUseStk, 0);
    chk("rst_ovf", aOvf, 0);
    chk("rst_unf", aUnf, 0);
    chk("rst_popdata", aPopData, 0);
    aReset = 1'b0;
    #1;
    chk("post_rst_ready", aReady, 1);
    chk("post_rst_empty", aEmpty, 1);
    mStack.delete();
    mOvf = 1'b0; mUnf = 1'b0; mPopData = '0;
  endtask

  // One request on DUT A, observed until Ready returns, checked against the model
  task automatic doOp(input bit c, input bit p, input bit u, input logic [31:0] d);
    int n = 0;
    int readyN = -1, pvN = -1, pvCnt = 0, wrCnt = 0, useCnt = 0;
    logic [31:0] wrAddr = '0, wrData = '0, pvData = '0;
    int eReadyN = 0, ePvN = -1, eWr = 0, eUse = 0;
    logic [31:0] eAddr = '0, eData = '0, ePd = '0;
    while (!aReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk("ready_before_op", aReady, 1);
    aClear = c; aPop = p; aPush = u; aPushData = d;
    @(posedge Clock);
    for (int i = 0; i < 12 && readyN < 0; i++) begin
      @(negedge Clock);
      if (i == 0) begin
        aClear = 1'b0; aPop = 1'b0; aPush = 1'b0;
      end
      if (aMemWrite) begin
        wrCnt++; wrAddr = aMemAddr; wrData = aMemDataIn;
      end
      if (aMemUseStk) useCnt++;
      if (aPopValid) begin
        pvCnt++; pvN = i; pvData = aPopData;
      end
      if (aReady) readyN = i;
    end
    if (c) begin
      mStack.delete();
    end else if (p) begin
      if (mStack.size() == 0) begin
        mUnf = 1'b1;
      end else begin
        ePd = mStack.pop_back();
        mPopData = ePd;
        ePvN = A_RL + 1; eReadyN = A_RL + 1; eUse = A_RL + 1;
      end
    end else if (u) begin
      if (mStack.size() == A_DEPTH) begin
        mOvf = 1'b1;
      end else begin
        eAddr = mStack.size(); eData = d;
        mStack.push_back(d);
        eWr = 1; eReadyN = 1; eUse = 1;
      end
    end
    chk("ready_latency", readyN, eReadyN);
    chk("write_count", wrCnt, eWr);
    if (eWr != 0) begin
      chk("write_addr", wrAddr, eAddr);
      chk("write_data", wrData, eData);
    end
    chk("usestk_cycles", useCnt, eUse);
    chk("popvalid_count", pvCnt, (ePvN >= 0) ? 1 : 0);
    if (ePvN >= 0) begin
      chk("pop_latency", pvN, ePvN);
      chk("pop_data", pvData, ePd);
    end
    chk("sp", aSp, mStack.size());
    chk("full", aFull, mStack.size() == A_DEPTH);
    chk("empty", aEmpty, mStack.size() == 0);
    chk("overflow", aOvf, mOvf);
    chk("underflow", aUnf, mUnf);
    chk("popdata_hold", aPopData, mPopData);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    int pvSeen;
    int lat;
    logic [31:0] latData;
    aReset = 1'b1; aPush = 1'b0; aPop = 1'b0; aClear = 1'b0; aPushData = '0;
    bReset = 1'b1; bPush = 1'b0; bPop = 1'b0; bClear = 1'b0; bPushData = '0;

    // Directed table: {clear, pop, push, data} -> {SP, PopData, Overflow, Underflow}
    tbl[0]  = mk(0, 0, 1, 32'hDEADBEEF, 1, 32'h0,        0, 0);
    tbl[1]  = mk(0, 0, 1, 32'h12345678, 2, 32'h0,        0, 0);
    tbl[2]  = mk(0, 1, 0, 32'h0,        1, 32'h12345678, 0, 0);
    tbl[3]  = mk(0, 1, 0, 32'h0,        0, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(0, 1, 0, 32'h0,        0, 32'hDEADBEEF, 0, 1);
    tbl[5]  = mk(0, 0, 1, 32'h0000000A, 1, 32'hDEADBEEF, 0, 1);
    tbl[6]  = mk(0, 1, 1, 32'h00000BAD, 0, 32'h0000000A, 0, 1);
    tbl[7]  = mk(0, 0, 1, 32'h1,        1, 32'h0000000A, 0, 1);
    tbl[8]  = mk(0, 0, 1, 32'h2,        2, 32'h0000000A, 0, 1);
    tbl[9]  = mk(0, 0, 1, 32'h3,        3, 32'h0000000A, 0, 1);
    tbl[10] = mk(1, 0, 1, 32'h77,       0, 32'h0000000A, 0, 1);
    tbl[11] = mk(0, 0, 1, 32'h1,        1, 32'h0000000A, 0, 1);
    tbl[12] = mk(0, 0, 1, 32'h2,        2, 32'h0000000A, 0, 1);
    tbl[13] = mk(0, 0, 1, 32'h3,        3, 32'h0000000A, 0, 1);
    tbl[14] = mk(0, 0, 1, 32'h4,        4, 32'h0000000A, 0, 1);
    tbl[15] = mk(0, 0, 1, 32'h5,        4, 32'h0000000A, 1, 1);
    tbl[16] = mk(0, 1, 0, 32'h0,        3, 32'h4,        1, 1);

    resetA();
    for (int i = 0; i < 17; i++) begin
      doOp(tbl[i].c, tbl[i].p, tbl[i].u, tbl[i].d);
      chk($sformatf("tbl%0d_sp", i), aSp, tbl[i].eSp);
      chk($sformatf("tbl%0d_popdata", i), aPopData, tbl[i].ePd);
      chk($sformatf("tbl%0d_ovf", i), aOvf, tbl[i].eOvf);
      chk($sformatf("tbl%0d_unf", i), aUnf, tbl[i].eUnf);
    end
    chk("tbl_end_ready", aReady, 1);

    // Random requests against the queue model
    resetA();
    for (int i = 0; i < 300; i++) begin
      doOp($urandom_range(0, 19) == 0, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 60, $urandom);
    end

    // DUT B: reset aborting a READ_LAT=3 pop
    repeat (2) @(negedge Clock);
    chk("b_rst_ready", bReady, 0);
    chk("b_rst_empty", bEmpty, 1);
    chk("b_rst_sp", bSp, 0);
    bReset = 1'b0;
    #1;
    bPush = 1'b1; bPushData = 32'h55;
    @(posedge Clock);
    @(negedge Clock);
    bPush = 1'b0;
    chk("b_push_memwrite", bMemWrite, 1);
    chk("b_push_data", bMemDataIn, 32'h55);
    chk("b_push_addr", bMemAddr, 0);
    @(negedge Clock);
    chk("b_push_sp", bSp, 1);
    chk("b_push_ready", bReady, 1);
    bPop = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bPop = 1'b0;
    chk("b_pop_usestk", bMemUseStk, 1);
    chk("b_pop_addr", bMemAddr, 0);
    chk("b_pop_busy", bReady, 0);
    pvSeen = 0;
    bReset = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      if (bPopValid) pvSeen++;
    end
    chk("b_abort_ready", bReady, 0);
    chk("b_abort_sp", bSp, 0);
    chk("b_abort_empty", bEmpty, 1);
    chk("b_abort_usestk", bMemUseStk, 0);
    bReset = 1'b0;
    @(negedge Clock);
    chk("b_ready_after_rst", bReady, 1);
    repeat (6) begin
      if (bPopValid) pvSeen++;
      @(negedge Clock);
    end
    chk("b_abort_popvalid", pvSeen, 0);
    chk("b_abort_popdata", bPopData, 0);
    chk("b_abort_ovf", bOvf, 0);
    chk("b_abort_unf", bUnf, 0);
    chk("b_abort_full", bFull, 0);

    // DUT B: full pop latency with READ_LAT=3
    bPush = 1'b1; bPushData = 32'h66;
    @(posedge Clock);
    @(negedge Clock);
    bPush = 1'b0;
    @(negedge Clock);
    chk("b_push2_ready", bReady, 1);
    bPop = 1'b1;
    @(posedge Clock);
    lat = -1;
    latData = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (i == 0) bPop = 1'b0;
      if (bPopValid && lat < 0) begin
        lat = i; latData = bPopData;
      end
    end
    chk("b_pop_latency", lat, B_RL + 1);
    chk("b_pop_data", latData, 32'h66);
    chk("b_pop_sp", bSp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
